// File: rtl/pipe_skid_stage.sv
// rtl/pipe_skid_stage.sv - pipeline stage register with two-entry skid buffer,
// kill-to-NOP that keeps the PC field, exception PC capture and a stall counter.
module pipe_skid_stage #(
  parameter int               WIDTH    = 128,
  parameter int               KEEP_LSB = 0,
  parameter int               KEEP_W   = 32,
  parameter logic [WIDTH-1:0] NOP_WORD = '0,
  parameter int               CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              itr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic [1:0]        occupancy,
  output logic [KEEP_W-1:0] epc,
  output logic              epc_valid,
  output logic [CNT_W-1:0]  stall_cycles
);

  // When KEEP_W == WIDTH the shift wraps to zero and the subtraction yields all ones.
  localparam logic [WIDTH-1:0] KEEP_MASK = ((WIDTH'(1) << KEEP_W) - WIDTH'(1)) << KEEP_LSB;
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  logic              r_main_valid;
  logic [WIDTH-1:0]  r_main_data;
  logic              r_skid_valid;
  logic [WIDTH-1:0]  r_skid_data;
  logic [KEEP_W-1:0] r_epc;
  logic              r_epc_valid;
  logic [CNT_W-1:0]  r_stall;

  logic              w_kill;
  logic              w_in_fire;
  logic              w_out_fire;
  logic [WIDTH-1:0]  w_kill_data;

  assign w_kill      = flush | itr;
  assign in_ready    = reset_n & ~r_skid_valid & ~w_kill;
  assign w_in_fire   = in_valid & in_ready;
  assign w_out_fire  = r_main_valid & out_ready;
  assign w_kill_data = (NOP_WORD & ~KEEP_MASK) | (r_main_data & KEEP_MASK);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_main_valid <= 1'b0;
      r_main_data  <= NOP_WORD;
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
      r_epc        <= '0;
      r_epc_valid  <= 1'b0;
    end else begin
      r_epc_valid <= 1'b0;
      if (w_kill) begin
        r_main_valid <= 1'b0;
        r_skid_valid <= 1'b0;
        r_main_data  <= w_kill_data;
        if (itr && r_main_valid) begin
          r_epc       <= r_main_data[KEEP_LSB +: KEEP_W];
          r_epc_valid <= 1'b1;
        end
      end else if (!r_main_valid) begin
        if (w_in_fire) begin
          r_main_valid <= 1'b1;
          r_main_data  <= in_data;
        end
      end else if (w_out_fire) begin
        // Skid entry is older than anything arriving now; in_ready is low while it is held.
        if (r_skid_valid) begin
          r_main_data  <= r_skid_data;
          r_skid_valid <= 1'b0;
        end else if (w_in_fire) begin
          r_main_data  <= in_data;
        end else begin
          r_main_valid <= 1'b0;
        end
      end else if (w_in_fire) begin
        r_skid_valid <= 1'b1;
        r_skid_data  <= in_data;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stall <= '0;
    end else if (r_main_valid && !out_ready && (r_stall != CNT_MAX)) begin
      r_stall <= r_stall + CNT_W'(1);
    end
  end

  assign out_valid    = r_main_valid;
  assign out_data     = r_main_data;
  assign occupancy    = {1'b0, r_main_valid} + {1'b0, r_skid_valid};
  assign epc          = r_epc;
  assign epc_valid    = r_epc_valid;
  assign stall_cycles = r_stall;

endmodule

// File: doc/pipe_skid_stage.md
# pipe_skid_stage

Parametrised pipeline stage register that replaces fixed stall/flush stage registers between core pipeline stages. It carries one packed stage payload with a valid/ready handshake and a two-entry skid buffer, so upstream never needs a combinational stall path from downstream. Flush and interrupt kill the stage contents and inject a NOP payload while preserving a designated field such as the PC. On interrupt it also reports the killed instruction's preserved field as an exception PC. It sits between any two stages (fetch/decode, decode/execute, ...), one instance per boundary.

## Interface
- WIDTH, 128: payload width in bits.
- KEEP_LSB, 0: LSB index of the field preserved across a kill (PC field).
- KEEP_W, 32: width of the preserved field; KEEP_LSB+KEEP_W <= WIDTH.
- NOP_WORD, '0: payload value injected on kill and after reset, excluding the keep field.
- CNT_W, 16: width of the stall counter.

- clk  input  1  clock, all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- flush  input  1  kill stage contents (branch mispredict).
- itr  input  1  kill stage contents and capture the exception PC.
- in_valid  input  1  upstream payload valid.
- in_ready  output  1  stage can accept; in_ready = reset_n & !skid_valid & !flush & !itr.
- in_data  input  WIDTH  upstream payload.
- out_valid  output  1  main entry valid (registered).
- out_ready  input  1  downstream accepts.
- out_data  output  WIDTH  main entry payload (registered).
- occupancy  output  2  main_valid + skid_valid (0..2).
- epc  output  KEEP_W  keep field of the entry killed by itr.
- epc_valid  output  1  one-cycle pulse, epc updated.
- stall_cycles  output  CNT_W  saturating count of out_valid & !out_ready cycles.

## Operation
- State: main {valid, data} drives out_*; skid {valid, data} holds overflow. in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Normal cycle (no kill):
  - main empty, in_fire: in_data -> main.
  - main full, out_fire, skid empty: in_fire ? in_data -> main : main_valid <= 0.
  - main full, !out_fire, in_fire: in_data -> skid.
  - main full, out_fire, skid full: skid -> main, skid_valid <= 0. in_ready is 0, so no input is accepted.
- Order is strictly preserved; the skid entry is always older than any new input.
- Kill (flush | itr), with priority over all transfers:
  - main_valid <= 0 and skid_valid <= 0.
  - out_data <= NOP_WORD with bits [KEEP_LSB +: KEEP_W] retained from the current out_data.
  - in_ready is 0 in the kill cycle, so no input is lost or accepted.
- itr with main_valid = 1: epc <= out_data keep field and epc_valid pulses the next cycle. With main_valid = 0, epc is unchanged and there is no pulse. flush alone never touches epc.
- When main_valid = 0 and no kill has occurred, out_data holds its last loaded value. Downstream must qualify it with out_valid.
- stall_cycles increments when out_valid & !out_ready and saturates at 2^CNT_W-1. Only reset clears it.

## Timing
- Reset (async assert, sync-safe release) sets:
  - main_valid = 0, skid_valid = 0.
  - out_data = NOP_WORD.
  - epc = 0, epc_valid = 0, stall_cycles = 0, occupancy = 0.
  - in_ready = 0 while reset_n is low.
- Latency: in_fire at edge N gives out_valid/out_data at N+1. Throughput is one payload per cycle with out_ready held high.
- in_ready is a function of registered skid_valid plus flush/itr only. There is no combinational path from out_ready.
- out_ready deasserting with main full: the first extra input goes to skid and in_ready drops the next cycle.
- Simultaneous out_fire and in_fire with skid full cannot occur, because in_ready = 0.
- Kill is asserted while stalled: both entries are dropped and stall counting stops, since out_valid = 0 next cycle.
- Reset asserted mid-transfer: all state is cleared immediately; the in-flight payload is discarded.

## Test plan
- Streaming: out_ready = 1, in_data = 1..8 back-to-back → out_data = 1..8 on consecutive cycles, each one cycle after input; occupancy stays at 1.
- Backpressure: stream 1..4, out_ready = 0 for 3 cycles from payload 2 → skid holds 3, in_ready = 0, occupancy = 2, stall_cycles = 3. On release the output is exactly 1,2,3,4 with no loss or duplication.
- Flush: main = 0x...0000_1040 (PC 0x1040), skid full, flush for one cycle → out_valid = 0, occupancy = 0, out_data = NOP_WORD with keep field 0x1040, epc_valid = 0.
- Interrupt: main valid with PC 0x2000, itr for one cycle → next cycle epc = 0x2000 and epc_valid = 1 for exactly one cycle. A second itr while empty gives no pulse and epc stays 0x2000.
- Kill vs input: in_valid = 1 with flush = 1 → in_ready = 0 that cycle, the payload is held upstream and accepted the next cycle.
- Reset and saturation:
  - CNT_W = 4, out_valid held with out_ready = 0 for 20 cycles → stall_cycles = 15.
  - Then assert reset_n = 0 mid-cycle → all outputs return to their reset values asynchronously.
